// File: rtl/adxl362_accel_reader.sv
// ADXL362 SPI reader: after power-up, puts the part into measurement mode,
// then reads the 8-bit X/Y registers once per sample tick and presents them
// as signed tilt values for the ball-motion logic.
module adxl362_accel_reader #(
    parameter int SCLK_DIV      = 25,
    parameter int POWERUP_WAIT  = 600000,
    parameter int CS_GAP        = 50,
    parameter int SAMPLE_PERIOD = 1000000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic [7:0] accel_x,
    output logic [7:0] accel_y,
    output logic       sample_valid,
    output logic       init_done
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int PW_W  = $clog2(POWERUP_WAIT + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD);

    // Transfer words, left-aligned; the config write only uses the top 24 bits.
    localparam logic [31:0] CFG_WORD = 32'h0A2D_0200;
    localparam logic [31:0] RD_WORD  = 32'h0B08_0000;

    typedef enum logic [2:0] {PWR_WAIT, CFG_XFER, GAP, WAIT_TICK, RD_XFER, UPDATE} state_t;

    state_t            state, state_n;
    logic [PW_W-1:0]   pw_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [4:0]        bit_last;
    logic              tail;
    logic [31:0]       tx_sh;
    logic [15:0]       rx_sh;
    logic [31:0]       load_word;
    logic [TMR_W-1:0]  tmr;
    logic              tick_pend;
    logic              tmr_wrap;
    logic              xfer, half_end, xfer_end;
    logic              start_cfg, start_rd, take_tick;

    assign xfer      = (state == CFG_XFER) || (state == RD_XFER);
    assign half_end  = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign xfer_end  = xfer && half_end && tail;
    assign bit_last  = (state == CFG_XFER) ? 5'd23 : 5'd31;
    assign load_word = start_cfg ? CFG_WORD : RD_WORD;
    assign tmr_wrap  = init_done && (tmr == TMR_W'(SAMPLE_PERIOD - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) state <= PWR_WAIT;
        else     state <= state_n;
    end

    // Next-state decode and one-cycle transfer/tick strobes.
    always_comb begin
        state_n   = state;
        start_cfg = 1'b0;
        start_rd  = 1'b0;
        take_tick = 1'b0;
        case (state)
            PWR_WAIT:  if (pw_cnt == PW_W'(POWERUP_WAIT - 1)) begin
                           state_n   = CFG_XFER;
                           start_cfg = 1'b1;
                       end
            CFG_XFER:  if (xfer_end) state_n = GAP;
            GAP:       if (gap_cnt == GAP_W'(CS_GAP - 1)) state_n = WAIT_TICK;
            WAIT_TICK: if (tick_pend) begin
                           take_tick = 1'b1;
                           start_rd  = 1'b1;
                           state_n   = RD_XFER;
                       end
            RD_XFER:   if (xfer_end) state_n = UPDATE;
            UPDATE:    state_n = GAP;
            default:   state_n = PWR_WAIT;
        endcase
    end

    // Power-up and inter-transaction wait counters, cleared outside their state.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pw_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            pw_cnt  <= (state == PWR_WAIT) ? pw_cnt + PW_W'(1) : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // SPI mode-0 shifter: low half, rise (capture), high half, fall (advance),
    // then one trailing low half before chip select is released.
    always_ff @(posedge CLK) begin
        if (rst) begin
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tail     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
        end else if (start_cfg || start_rd) begin
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= load_word[31];
            tx_sh    <= load_word;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tail     <= 1'b0;
        end else if (xfer) begin
            if (!half_end) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                if (tail) begin
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                end else if (!spi_sclk) begin
                    spi_sclk <= 1'b1;
                    // Only read captures matter; the config write's MISO is ignored.
                    if (state == RD_XFER) rx_sh <= {rx_sh[14:0], spi_miso};
                end else begin
                    spi_sclk <= 1'b0;
                    if (bit_cnt == bit_last) begin
                        tail <= 1'b1;
                    end else begin
                        bit_cnt  <= bit_cnt + 5'd1;
                        tx_sh    <= tx_sh << 1;
                        spi_mosi <= tx_sh[30];
                    end
                end
            end
        end
    end

    // Output latch: X arrives in the third byte (after command and address),
    // Y in the fourth; both update together with a one-cycle valid pulse.
    always_ff @(posedge CLK) begin
        if (rst) begin
            accel_x      <= '0;
            accel_y      <= '0;
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            sample_valid <= (state == UPDATE);
            if (state == UPDATE) begin
                accel_x <= rx_sh[15:8];
                accel_y <= rx_sh[7:0];
            end
            if (state == GAP) init_done <= 1'b1;
        end
    end

    // Sample timer: free-runs once configured; at most one tick is ever pending.
    always_ff @(posedge CLK) begin
        if (rst) begin
            tmr       <= '0;
            tick_pend <= 1'b0;
        end else if (init_done) begin
            tmr       <= tmr_wrap ? '0 : tmr + TMR_W'(1);
            tick_pend <= tmr_wrap || (tick_pend && !take_tick);
        end
    end

endmodule

// File: tb/tb_adxl362_accel_reader.sv
// Directed bench for adxl362_accel_reader: dut0 uses a 2000-cycle sample
// period, dut1 a 100-cycle period shorter than one read.
module tb_adxl362_accel_reader;

    localparam int DIV = 4;
    localparam int PW  = 100;
    localparam int GAPC = 8;
    localparam int RD_LEN  = 32 * 2 * DIV + DIV;
    localparam int CFG_LEN = 24 * 2 * DIV + DIV;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [1:0]      rst, miso, sclk, mosi, cs_n, sv, idn;
    logic [1:0][7:0] ax, ay;

    adxl362_accel_reader #(.SCLK_DIV(DIV), .POWERUP_WAIT(PW), .CS_GAP(GAPC), .SAMPLE_PERIOD(2000)) dut0 (
        .CLK(CLK), .rst(rst[0]), .spi_miso(miso[0]), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]),
        .spi_cs_n(cs_n[0]), .accel_x(ax[0]), .accel_y(ay[0]), .sample_valid(sv[0]), .init_done(idn[0]));

    adxl362_accel_reader #(.SCLK_DIV(DIV), .POWERUP_WAIT(PW), .CS_GAP(GAPC), .SAMPLE_PERIOD(100)) dut1 (
        .CLK(CLK), .rst(rst[1]), .spi_miso(miso[1]), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]),
        .spi_cs_n(cs_n[1]), .accel_x(ax[1]), .accel_y(ay[1]), .sample_valid(sv[1]), .init_done(idn[1]));

    // Stimulus-side controls (written only by the main thread).
    logic [31:0] mword [2];
    logic        noise;
    logic [1:0]  gap_arm;

    // Monitor/slave-model state (written only by the monitor).
    int          cyc = 0;
    logic [1:0]  pcs = 2'b11, psclk = 2'b00;
    logic [1:0][7:0] pax = '0, pay = '0;
    int          rises [2], len [2], l_rises [2], l_len [2], ends [2];
    int          sv_n [2], sv_cyc [2], rise_cyc [2], gap_run [2], min_gap [2], max_gap [2];
    logic [31:0] msh [2], l_mosi [2];
    int          viol = 0, unstable = 0;

    int n_tests = 0, n_fail = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0; len[d] = 0; l_rises[d] = 0; l_len[d] = 0; ends[d] = 0;
            sv_n[d] = 0; sv_cyc[d] = 0; rise_cyc[d] = 0; gap_run[d] = 0;
            min_gap[d] = 1000000; max_gap[d] = 0; msh[d] = '0; l_mosi[d] = '0;
        end
    end

    // Slave model and bus monitor: MISO shifts out MSB first in mode 0,
    // MOSI is decoded on every observed SCLK rise, windows and gaps are timed.
    always @(negedge CLK) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (sclk[d] && cs_n[d]) viol++;
            if (!rst[d] && !sv[d] && (ax[d] != pax[d] || ay[d] != pay[d])) unstable++;
            if (cs_n[d]) begin
                if (!pcs[d]) begin
                    l_rises[d] = rises[d]; l_len[d] = len[d]; l_mosi[d] = msh[d];
                    ends[d]++; rise_cyc[d] = cyc;
                end
                rises[d] = 0; len[d] = 0; msh[d] = '0; gap_run[d]++;
                miso[d] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                if (pcs[d]) begin
                    if (gap_arm[d]) begin
                        if (gap_run[d] < min_gap[d]) min_gap[d] = gap_run[d];
                        if (gap_run[d] > max_gap[d]) max_gap[d] = gap_run[d];
                    end
                    gap_run[d] = 0;
                end
                len[d]++;
                if (sclk[d] && !psclk[d]) begin
                    msh[d] = {msh[d][30:0], mosi[d]};
                    rises[d]++;
                end
                if (rises[d] < 32) begin
                    int idx;
                    idx = 31 - rises[d];
                    miso[d] = mword[d][idx];
                end else begin
                    miso[d] = 1'b0;
                end
            end
            if (sv[d]) begin sv_n[d]++; sv_cyc[d] = cyc; end
            pcs[d] = cs_n[d]; psclk[d] = sclk[d]; pax[d] = ax[d]; pay[d] = ay[d];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample point: just after the monitor has run on the falling edge.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_cs_rise(input int d, input int budget, input string tag);
        int e0, k;
        e0 = ends[d]; k = 0;
        while (ends[d] == e0 && k < budget) begin step(); k++; end
        chk(tag, 64'(ends[d] != e0), 64'd1);
    endtask

    task automatic wait_sv(input int d, input int budget, input string tag);
        int k;
        k = 0;
        while (!sv[d] && k < budget) begin step(); k++; end
        chk(tag, 64'(sv[d]), 64'd1);
    endtask

    // Starts in cycle 0 after reset release: CS must stay idle for PW cycles.
    task automatic pwr_check(input string tag);
        int hi;
        hi = 0;
        for (int i = 0; i < PW; i++) begin
            if (cs_n[0] && !sclk[0]) hi++;
            step();
        end
        chk({tag, "_idle"}, 64'(hi), 64'(PW));
        chk({tag, "_cs_fall"}, 64'(cs_n[0]), 64'd0);
    endtask

    logic [31:0] w_tab [4] = '{32'hA5A5_4C01, 32'h0000_807F, 32'hFFFF_00FF, 32'h1234_C3D2};
    logic [7:0]  x_tab [4] = '{8'h4C, 8'h80, 8'h00, 8'hC3};
    logic [7:0]  y_tab [4] = '{8'h01, 8'h7F, 8'hFF, 8'hD2};
    logic [31:0] w1_tab [4] = '{32'h0000_1122, 32'h0000_F00D, 32'h0000_7E81, 32'h0000_0203};
    logic [7:0]  x1_tab [4] = '{8'h11, 8'hF0, 8'h7E, 8'h02};
    logic [7:0]  y1_tab [4] = '{8'h22, 8'h0D, 8'h81, 8'h03};

    initial begin
        int t_prev, svb, k;
        rst = 2'b11; noise = 1'b0; gap_arm = 2'b00;
        mword[0] = '0; mword[1] = '0;
        repeat (3) step();
        rst[0] = 1'b0;

        // 1: reset state, power-up hold, configuration write, init_done timing
        chk("rst_cs_n", 64'(cs_n[0]), 64'd1);
        chk("rst_sclk", 64'(sclk[0]), 64'd0);
        chk("rst_mosi", 64'(mosi[0]), 64'd0);
        chk("rst_xy", 64'({ax[0], ay[0]}), 64'd0);
        chk("rst_flags", 64'({sv[0], idn[0]}), 64'd0);
        pwr_check("pwr");
        wait_cs_rise(0, 400, "cfg_end");
        chk("cfg_mosi", 64'(l_mosi[0]), 64'h000A_2D02);
        chk("cfg_rises", 64'(l_rises[0]), 64'd24);
        chk("cfg_len", 64'(l_len[0]), 64'(CFG_LEN));
        chk("init_early", 64'(idn[0]), 64'd0);
        step();
        chk("init_rise", 64'(idn[0]), 64'd1);

        // 2: first read with MISO bytes 00 00 1F E3
        mword[0] = 32'h0000_1FE3;
        wait_sv(0, 5000, "sv1_seen");
        chk("sv1_x", 64'(ax[0]), 64'h1F);
        chk("sv1_y", 64'(ay[0]), 64'hE3);
        chk("rd_mosi", 64'(l_mosi[0]), 64'h0B08_0000);
        chk("rd_rises", 64'(l_rises[0]), 64'd32);
        chk("rd_len", 64'(l_len[0]), 64'(RD_LEN));
        chk("sv_latency", 64'(sv_cyc[0] - rise_cyc[0]), 64'd1);
        t_prev = sv_cyc[0];
        step();
        chk("sv_width", 64'(sv[0]), 64'd0);

        // 3 + 6: periodic reads with MISO noise between transactions
        noise = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mword[0] = w_tab[i];
            wait_sv(0, 3000, $sformatf("per_sv%0d", i));
            chk($sformatf("per_x%0d", i), 64'(ax[0]), 64'(x_tab[i]));
            chk($sformatf("per_y%0d", i), 64'(ay[0]), 64'(y_tab[i]));
            chk($sformatf("per_gap%0d", i), 64'(sv_cyc[0] - t_prev), 64'd2000);
            chk($sformatf("per_len%0d", i), 64'(l_len[0]), 64'(RD_LEN));
            t_prev = sv_cyc[0];
            step();
        end
        chk("hold_between", 64'(unstable), 64'd0);
        noise = 1'b0;

        // 5: reset on the 10th SCLK rise of a read
        mword[0] = 32'h0000_5AA5;
        k = 0;
        while (!(!cs_n[0] && rises[0] == 10) && k < 3000) begin step(); k++; end
        chk("abort_point", 64'(rises[0]), 64'd10);
        svb = sv_n[0];
        rst[0] = 1'b1;
        step();
        chk("abort_cs_n", 64'(cs_n[0]), 64'd1);
        chk("abort_sclk", 64'(sclk[0]), 64'd0);
        chk("abort_xy", 64'({ax[0], ay[0]}), 64'd0);
        chk("abort_init", 64'(idn[0]), 64'd0);
        step();
        rst[0] = 1'b0;
        pwr_check("pwr2");
        wait_cs_rise(0, 400, "cfg2_end");
        chk("cfg2_mosi", 64'(l_mosi[0]), 64'h000A_2D02);
        chk("no_abort_sv", 64'(sv_n[0] - svb), 64'd0);
        wait_sv(0, 5000, "sv_after_abort");
        chk("post_x", 64'(ax[0]), 64'h5A);
        chk("post_y", 64'(ay[0]), 64'hA5);

        // 4: sample period shorter than a read -> back-to-back reads
        rst[1] = 1'b0;
        k = 0;
        while (!idn[1] && k < 600) begin step(); k++; end
        chk("fast_init", 64'(idn[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            mword[1] = w1_tab[i];
            wait_sv(1, 1000, $sformatf("fast_sv%0d", i));
            chk($sformatf("fast_x%0d", i), 64'(ax[1]), 64'(x1_tab[i]));
            chk($sformatf("fast_y%0d", i), 64'(ay[1]), 64'(y1_tab[i]));
            chk($sformatf("fast_len%0d", i), 64'(l_len[1]), 64'(RD_LEN));
            gap_arm[1] = 1'b1;
            step();
        end
        chk("fast_gap_min", 64'(min_gap[1] >= GAPC), 64'd1);
        chk("fast_back2back", 64'(max_gap[1] <= GAPC + 4), 64'd1);
        chk("fast_one_sv_per_read", 64'(ends[1] - sv_n[1]), 64'd1);
        chk("sclk_idle_cs_high", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
